// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//   Fetches one sprite row per horizontal line from a combinational sprite ROM
//   into a double-buffered line buffer. During active video it outputs the
//   current line's sprite pixel, with transparent pixels suppressed.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   frame_start         loads the sprite position shadow (pos_x/pos_y)
//   line_start          swaps line buffers and starts the fetch for next_line
//   next_line           screen row shown after this line_start
//   h_count, h_active   current pixel column and visible-area flag
//   rom_addr, rom_data  sprite ROM port (data returns in the same cycle)
//   pixel_valid/rgb     registered sprite pixel, one cycle after h_count
//   busy, overrun       fetch in progress / fetch aborted by line_start
module sprite_line_fetcher #(
  parameter int ADDRESS    = 10,
  parameter int COLOR_BITS = 24,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int COORD_BITS = 10,
  parameter logic [COLOR_BITS-1:0] TRANSP_KEY = 24'hFF00FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [COORD_BITS-1:0] next_line,
  input  logic [COORD_BITS-1:0] pos_x,
  input  logic [COORD_BITS-1:0] pos_y,
  input  logic [COORD_BITS-1:0] h_count,
  input  logic                  h_active,
  output logic [ADDRESS-1:0]    rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic                  pixel_valid,
  output logic [COLOR_BITS-1:0] pixel_rgb,
  output logic                  busy,
  output logic                  overrun
);

  localparam int COL_BITS = $clog2(SPRITE_W);
  localparam int ROW_BITS = ADDRESS - COL_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Extended-width bounds so coordinate compares never wrap.
  localparam logic [COORD_BITS:0] SPRITE_W_EXT = (COORD_BITS+1)'(SPRITE_W);
  localparam logic [COORD_BITS:0] SPRITE_H_EXT = (COORD_BITS+1)'(SPRITE_H);
  localparam logic [COL_BITS-1:0] COL_LAST     = COL_BITS'(SPRITE_W - 1);

  logic [1:0]            state_q, state_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [ADDRESS-1:0]    rom_addr_q, rom_addr_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [COORD_BITS-1:0] px_q, px_d;
  logic [COORD_BITS-1:0] py_q, py_d;
  logic [1:0]            valid_q, valid_d;   // per-bank "row complete" flags
  logic                  front_q, front_d;   // bank index currently displayed
  logic                  pixel_valid_q, pixel_valid_d;
  logic [COLOR_BITS-1:0] pixel_rgb_q, pixel_rgb_d;

  logic [COLOR_BITS-1:0] line_buf_q [0:1][0:SPRITE_W-1];

  logic [COORD_BITS-1:0] py_eff_s;
  logic [COORD_BITS:0]   row_diff_s;
  logic                  row_hit_s;
  logic [COL_BITS-1:0]   col_inc_s;
  logic                  buf_we_s;
  logic [COORD_BITS:0]   h_off_s;
  logic                  pix_hit_s;
  logic [COLOR_BITS-1:0] front_pix_s;

  // Row selection for the upcoming line; a coincident frame_start wins over the shadow.
  always_comb begin
    if (frame_start) begin
      py_eff_s = pos_y;
    end else begin
      py_eff_s = py_q;
    end
    row_diff_s = {1'b0, next_line} - {1'b0, py_eff_s};
    row_hit_s  = ({1'b0, next_line} >= {1'b0, py_eff_s}) && (row_diff_s < SPRITE_H_EXT);
    col_inc_s  = col_q + COL_BITS'(1);
  end

  // Fetch sequencer, buffer swap and position shadow next-state logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rom_addr_d = rom_addr_q;
    valid_d    = valid_q;
    front_d    = front_q;
    overrun_d  = 1'b0;
    buf_we_s   = 1'b0;
    if (frame_start) begin
      px_d = pos_x;
      py_d = pos_y;
    end else begin
      px_d = px_q;
      py_d = py_q;
    end
    if (line_start) begin
      // An unfinished fetch is dropped; its bank never got its valid flag.
      overrun_d        = (state_q == ST_FETCH);
      front_d          = ~front_q;
      valid_d[front_q] = 1'b0;   // old front becomes the new back bank
      if (row_hit_s) begin
        state_d    = ST_FETCH;
        col_d      = {COL_BITS{1'b0}};
        row_d      = row_diff_s[ROW_BITS-1:0];
        rom_addr_d = {row_diff_s[ROW_BITS-1:0], {COL_BITS{1'b0}}};
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          buf_we_s = 1'b1;
          if (col_q == COL_LAST) begin
            valid_d[~front_q] = 1'b1;
            state_d           = ST_DONE;
          end else begin
            col_d      = col_inc_s;
            rom_addr_d = {row_q, col_inc_s};
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_FETCH);
  end

  // Pixel lookup against the front bank; offset is computed one bit wider than the screen.
  always_comb begin
    h_off_s     = {1'b0, h_count} - {1'b0, px_q};
    front_pix_s = line_buf_q[front_q][h_off_s[COL_BITS-1:0]];
    pix_hit_s   = h_active && valid_q[front_q] &&
                  ({1'b0, h_count} >= {1'b0, px_q}) && (h_off_s < SPRITE_W_EXT);
    if (pix_hit_s && (front_pix_s != TRANSP_KEY)) begin
      pixel_valid_d = 1'b1;
      pixel_rgb_d   = front_pix_s;
    end else begin
      pixel_valid_d = 1'b0;
      pixel_rgb_d   = {COLOR_BITS{1'b0}};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      col_q         <= {COL_BITS{1'b0}};
      row_q         <= {ROW_BITS{1'b0}};
      rom_addr_q    <= {ADDRESS{1'b0}};
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      px_q          <= {COORD_BITS{1'b0}};
      py_q          <= {COORD_BITS{1'b0}};
      valid_q       <= 2'b00;
      front_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_rgb_q   <= {COLOR_BITS{1'b0}};
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      rom_addr_q    <= rom_addr_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      px_q          <= px_d;
      py_q          <= py_d;
      valid_q       <= valid_d;
      front_q       <= front_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_rgb_q   <= pixel_rgb_d;
    end
  end

  // Line buffer storage; contents are qualified by the valid flags, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we_s && !rst) begin
      line_buf_q[~front_q][col_q] <= rom_data;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_rgb   = pixel_rgb_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher
//   Directed sequence with randomized ROM contents and randomized lines.
//   The reference model tracks which sprite row each screen line displays
//   and when a fetch is due to finish, and predicts every output each cycle.
module tb_sprite_line_fetcher;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [9:0]  next_line;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [9:0]  h_count;
  logic        h_active;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data;
  logic        pixel_valid;
  logic [23:0] pixel_rgb;
  logic        busy;
  logic        overrun;

  logic [23:0] rom [0:1023];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int m_px, m_py;
  int m_fetch_row;   // row being fetched, -1 when no fetch in flight
  int m_fetch_cnt;   // words written so far in the current fetch
  int m_done_row;    // row completely fetched into the back bank, -1 if none
  int m_disp_row;    // row shown on the current line, -1 if none
  int m_addr;        // expected rom_addr

  sprite_line_fetcher dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .next_line(next_line), .pos_x(pos_x), .pos_y(pos_y), .h_count(h_count),
    .h_active(h_active), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0;
    m_fetch_row = -1; m_fetch_cnt = 0;
    m_done_row = -1; m_disp_row = -1;
    m_addr = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare all outputs.
  task automatic step(input logic r, input logic fs, input logic ls,
                      input int nl, input int hc, input logic ha);
    logic        e_pv, e_ov;
    logic [23:0] e_rgb, c;
    int          row, h;
    h = hc % 1024;
    rst = r; frame_start = fs; line_start = ls;
    next_line = nl[9:0]; h_count = h[9:0]; h_active = ha;
    e_pv = 1'b0; e_rgb = 24'h000000; e_ov = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (ha && m_disp_row >= 0 && h >= m_px && h - m_px < 32) begin
        c = rom[m_disp_row * 32 + (h - m_px)];
        if (c != KEY) begin
          e_pv = 1'b1; e_rgb = c;
        end
      end
      if (fs) begin
        m_px = int'(pos_x); m_py = int'(pos_y);
      end
      if (ls) begin
        if (m_fetch_row >= 0) begin
          e_ov = 1'b1;
          m_disp_row = -1;
        end else begin
          m_disp_row = m_done_row;
        end
        m_done_row = -1;
        row = nl - m_py;
        if (nl >= m_py && row < 32) begin
          m_fetch_row = row; m_fetch_cnt = 0; m_addr = row * 32;
        end else begin
          m_fetch_row = -1;
        end
      end else if (m_fetch_row >= 0) begin
        m_fetch_cnt++;
        if (m_fetch_cnt == 32) begin
          m_done_row = m_fetch_row; m_fetch_row = -1;
        end else begin
          m_addr = m_fetch_row * 32 + m_fetch_cnt;
        end
      end
    end
    @(posedge clk); #1;
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("busy", 32'(busy), 32'(m_fetch_row >= 0));
    chk("overrun", 32'(overrun), 32'(e_ov));
    chk("pixel_valid", 32'(pixel_valid), 32'(e_pv));
    chk("pixel_rgb", 32'(pixel_rgb), 32'(e_rgb));
  endtask

  task automatic run_line(input int nl, input int h_lo, input int h_hi, input int idle);
    step(1'b0, 1'b0, 1'b1, nl, 0, 1'b0);
    for (int h = h_lo; h <= h_hi; h++) step(1'b0, 1'b0, 1'b0, 0, h, 1'b1);
    for (int i = 0; i < idle; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic new_frame(input int x, input int y);
    pos_x = x[9:0]; pos_y = y[9:0];
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int x, y, nl, lo, len;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 7) == 0) rom[i] = KEY;
      else rom[i] = 24'($urandom);
    end
    for (int i = 0; i < 7; i++) rom[i] = 24'h123456 + 24'(i * 24'h010101);
    rom[5] = KEY;
    pos_x = 10'd0; pos_y = 10'd0;
    model_reset();

    // Reset state
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Basic fetch of row 0, then display it while row 1 is fetched
    new_frame(100, 50);
    run_line(50, 0, -1, 40);
    run_line(51, 0, 200, 0);
    // Row 1 shown; rows outside the sprite never fetch
    run_line(49, 0, 200, 0);
    run_line(82, 0, 200, 0);
    run_line(60, 0, 200, 0);
    run_line(61, 0, 200, 0);

    // Abort: second line_start 10 cycles after the first
    run_line(62, 0, -1, 9);
    run_line(63, 0, 200, 0);
    run_line(64, 0, 200, 0);

    // Right-edge position, coincident frame_start + line_start fetching row 0
    pos_x = 10'd1020; pos_y = 10'd70;
    step(1'b0, 1'b1, 1'b1, 70, 0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_line(71, 990, 1064, 0);

    // Randomized lines, some with short gaps that abort
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 100));
        new_frame(x, y);
      end else begin
        y = m_py; x = m_px;
      end
      nl  = y + int'($urandom_range(0, 40)) - 3;
      if (nl < 0) nl = 0;
      lo  = ($urandom_range(0, 1) == 0) ? x - int'($urandom_range(0, 10)) : int'($urandom_range(0, 1000));
      if (lo < 0) lo = 0;
      len = int'($urandom_range(0, 60));
      run_line(nl, lo, lo + len - 1, int'($urandom_range(0, 30)));
    end

    // Reset in the middle of a fetch, then resume from clean state
    new_frame(8, 0);
    run_line(3, 0, -1, 5);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_line(5, 0, -1, 36);
    run_line(6, 0, 60, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
